// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, requester and grant encodings for mem_rr_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Round-robin pointer values: which requester wins a tie next.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One-hot grant encodings as seen on grant_o.
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_0    = 2'b01;
  localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick, one-hot result
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  // A lone valid always wins; the pointer only breaks ties.
  always_comb begin
    grant_o = GRANT_NONE;
    case (valid_i)
      2'b01:   grant_o = GRANT_0;
      2'b10:   grant_o = GRANT_1;
      2'b11:   grant_o = (ptr_i == REQ0) ? GRANT_0 : GRANT_1;
      default: grant_o = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-port round-robin sequencer in front of one memory port (optional MEM_ARB_TIMEOUT_EN)
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_valid_i,
  input  logic                  req0_wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [WIDTH-1:0]      req0_wdata_i,
  output logic                  req0_ready_o,
  output logic [WIDTH-1:0]      req0_rdata_o,
  input  logic                  req1_valid_i,
  input  logic                  req1_wr_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [WIDTH-1:0]      req1_wdata_i,
  output logic                  req1_ready_o,
  output logic [WIDTH-1:0]      req1_rdata_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic [1:0]            grant_o
`ifdef MEM_ARB_TIMEOUT_EN
  , output logic                err_o
`endif
);

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [1:0]            grant_q, grant_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                  ready0_q, ready0_d;
  logic                  ready1_q, ready1_d;
  logic [WIDTH-1:0]      rdata0_q, rdata0_d;
  logic [WIDTH-1:0]      rdata1_q, rdata1_d;
  logic [1:0]            pick;
  logic                  finish;
  logic                  capture;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
`endif

  rr_pick2 u_pick (
    .valid_i (
      {req1_valid_i, req0_valid_i}),
    .ptr_i   (ptr_q),
    .grant_o (pick)
  );

  // Next-state and next-output logic for the IDLE/BUSY/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    mem_valid_d = mem_valid_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ready0_d    = ready0_q;
    ready1_d    = ready1_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    finish      = 1'b0;
    capture     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    timer_d     = timer_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick != GRANT_NONE) begin
          state_d     = ST_BUSY;
          grant_d     = pick;
          mem_valid_d = 1'b1;
          if (pick == GRANT_0) begin
            mem_wr_d    = req0_wr_rd_en_i;
            mem_addr_d  = req0_addr_i;
            mem_wdata_d = req0_wdata_i;
          end else begin
            mem_wr_d    = req1_wr_rd_en_i;
            mem_addr_d  = req1_addr_i;
            mem_wdata_d = req1_wdata_i;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      ST_BUSY: begin
        // Requester inputs are deliberately not looked at here.
        if (mem_ready_i) begin
          finish  = 1'b1;
          capture = !mem_wr_q;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timer_q == TIMER_LAST) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
        if (finish) begin
          state_d     = ST_RESP;
          mem_valid_d = 1'b0;
          ptr_d       = (grant_q == GRANT_0) ? REQ1 : REQ0;
          if (grant_q == GRANT_0) begin
            ready0_d = 1'b1;
            if (capture) rdata0_d = mem_rdata_i;
          end else begin
            ready1_d = 1'b1;
            if (capture) rdata1_d = mem_rdata_i;
          end
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
        grant_d  = GRANT_NONE;
`ifdef MEM_ARB_TIMEOUT_EN
        err_d    = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= REQ0;
      grant_q     <= GRANT_NONE;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      timer_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      mem_valid_q <= mem_valid_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef MEM_ARB_TIMEOUT_EN
      timer_q     <= timer_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req0_ready_o   = ready0_q;
  assign req0_rdata_o   = rdata0_q;
  assign req1_ready_o   = ready1_q;
  assign req1_rdata_o   = rdata1_q;
  assign mem_valid_o    = mem_valid_q;
  assign mem_wr_rd_en_o = mem_wr_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign grant_o        = grant_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err_o          = err_q;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - directed self-checking bench for mem_rr_arbiter (MEM_ARB_TIMEOUT_EN adds timeout steps)
module tb_mem_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_valid, r0_wr, r1_valid, r1_wr;
  logic [3:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_ready, r1_ready;
  logic [3:0] r0_rdata, r1_rdata;
  logic       m_valid, m_wr, m_ready;
  logic [3:0] m_addr, m_wdata, m_rdata;
  logic [1:0] grant;
`ifdef MEM_ARB_TIMEOUT_EN
  logic       err;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Memory model: read data is address + 1.
  assign m_rdata = m_addr + 4'd1;

  mem_rr_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req0_valid_i    (r0_valid),
    .req0_wr_rd_en_i (r0_wr),
    .req0_addr_i     (r0_addr),
    .req0_wdata_i    (r0_wdata),
    .req0_ready_o    (r0_ready),
    .req0_rdata_o    (r0_rdata),
    .req1_valid_i    (r1_valid),
    .req1_wr_rd_en_i (r1_wr),
    .req1_addr_i     (r1_addr),
    .req1_wdata_i    (r1_wdata),
    .req1_ready_o    (r1_ready),
    .req1_rdata_o    (r1_rdata),
    .mem_valid_o     (m_valid),
    .mem_wr_rd_en_o  (m_wr),
    .mem_addr_o      (m_addr),
    .mem_wdata_o     (m_wdata),
    .mem_ready_i     (m_ready),
    .mem_rdata_i     (m_rdata),
    .grant_o         (grant)
`ifdef MEM_ARB_TIMEOUT_EN
    , .err_o         (err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_r0ready"}, 32'(r0_ready), 32'd0);
    chk({tag, "_r1ready"}, 32'(r1_ready), 32'd0);
  endtask

  initial begin
    logic [1:0] exp_g;
    rst = 1'b1;
    r0_valid = 1'b1; r0_wr = 1'b0; r0_addr = 4'd0; r0_wdata = 4'd0;
    r1_valid = 1'b0; r1_wr = 1'b0; r1_addr = 4'd0; r1_wdata = 4'd0;
    m_ready = 1'b0;

    // Reset held two edges with req0 asking: nothing may start.
    step();
    chk_idle_outputs("rst1");
    chk("rst1_r0rdata", 32'(r0_rdata), 32'd0);
    chk("rst1_maddr", 32'(m_addr), 32'd0);
    step();
    chk_idle_outputs("rst2");

    // req0 write addr 3 data A, zero-wait memory.
    rst = 1'b0;
    r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 4'd3; r0_wdata = 4'hA;
    m_ready = 1'b1;
    step();
    chk("wr_mvalid", 32'(m_valid), 32'd1);
    chk("wr_maddr", 32'(m_addr), 32'd3);
    chk("wr_mwdata", 32'(m_wdata), 32'hA);
    chk("wr_mwr", 32'(m_wr), 32'd1);
    chk("wr_grant", 32'(grant), 32'b01);
    chk("wr_r0ready_early", 32'(r0_ready), 32'd0);
    r0_valid = 1'b0;
    step();
    chk("wr_r0ready", 32'(r0_ready), 32'd1);
    chk("wr_r1ready", 32'(r1_ready), 32'd0);
    chk("wr_mvalid_drop", 32'(m_valid), 32'd0);
    chk("wr_r0rdata_hold", 32'(r0_rdata), 32'd0);
    step();
    chk_idle_outputs("wr_done");

    // Continuous contention; pointer now favours req1 after req0 was served.
    r0_valid = 1'b1; r0_wr = 1'b0; r0_addr = 4'd5;
    r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 4'd9;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      step();
      chk("rr_grant", 32'(grant), 32'(exp_g));
      chk("rr_maddr", 32'(m_addr), (i % 2 == 0) ? 32'd9 : 32'd5);
      step();
      chk("rr_r0ready", 32'(r0_ready), 32'(exp_g[0]));
      chk("rr_r1ready", 32'(r1_ready), 32'(exp_g[1]));
      step();
      chk("rr_resp_grant", 32'(grant), 32'd0);
      if (i == 3) begin
        r0_valid = 1'b0;
        r1_valid = 1'b0;
      end
    end
    chk("rr_r0rdata", 32'(r0_rdata), 32'd6);
    chk("rr_r1rdata", 32'(r1_rdata), 32'd10);

    // Slow memory; req1 drops valid and changes address mid-BUSY.
    m_ready = 1'b0;
    r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 4'd2;
    step();
    chk("slow_grant", 32'(grant), 32'b10);
    r1_valid = 1'b0; r1_addr = 4'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("slow_maddr", 32'(m_addr), 32'd2);
      chk("slow_mvalid", 32'(m_valid), 32'd1);
      chk("slow_r1ready", 32'(r1_ready), 32'd0);
    end
    m_ready = 1'b1;
    step();
    chk("slow_r1ready_pulse", 32'(r1_ready), 32'd1);
    chk("slow_r1rdata", 32'(r1_rdata), 32'd3);
    m_ready = 1'b0;
    step();
    chk_idle_outputs("slow_done");

    // Complete one req0 write so the pointer favours req1.
    r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 4'd1; r0_wdata = 4'd5;
    m_ready = 1'b1;
    step();
    chk("pre_grant", 32'(grant), 32'b01);
    r0_valid = 1'b0;
    step();
    chk("pre_r0ready", 32'(r0_ready), 32'd1);
    step();
    // Start req1 read, then reset while it is in BUSY.
    r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 4'd4;
    m_ready = 1'b0;
    step();
    chk("abort_grant", 32'(grant), 32'b10);
    chk("abort_mvalid", 32'(m_valid), 32'd1);
    rst = 1'b1; m_ready = 1'b1; r1_valid = 1'b0;
    step();
    chk_idle_outputs("abort");
    chk("abort_r0rdata", 32'(r0_rdata), 32'd0);
    chk("abort_r1rdata", 32'(r1_rdata), 32'd0);
    chk("abort_maddr", 32'(m_addr), 32'd0);
    // Pointer must be back at req0: a tie now goes to req0.
    rst = 1'b0;
    r0_valid = 1'b1; r0_wr = 1'b0; r0_addr = 4'd8;
    r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 4'd12;
    step();
    chk("post_rst_grant", 32'(grant), 32'b01);
    chk("post_rst_maddr", 32'(m_addr), 32'd8);
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    chk("post_rst_r0ready", 32'(r0_ready), 32'd1);
    chk("post_rst_r1ready", 32'(r1_ready), 32'd0);
    chk("post_rst_r0rdata", 32'(r0_rdata), 32'd9);
    step();
    chk_idle_outputs("post_rst_done");

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers; pointer favours req1 here.
    m_ready = 1'b0;
    r0_valid = 1'b1; r0_wr = 1'b0; r0_addr = 4'd2;
    r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 4'd3;
    step();
    chk("to_grant", 32'(grant), 32'b10);
    for (int i = 0; i < 14; i++) begin
      step();
      chk("to_wait_r1ready", 32'(r1_ready), 32'd0);
      chk("to_wait_err", 32'(err), 32'd0);
      chk("to_wait_mvalid", 32'(m_valid), 32'd1);
    end
    step();
    chk("to_r1ready", 32'(r1_ready), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_mvalid", 32'(m_valid), 32'd0);
    chk("to_r1rdata", 32'(r1_rdata), 32'd0);
    r1_valid = 1'b0;
    step();
    chk("to_err_clear", 32'(err), 32'd0);
    chk("to_idle_grant", 32'(grant), 32'd0);
    m_ready = 1'b1;
    step();
    chk("to_next_grant", 32'(grant), 32'b01);
    r0_valid = 1'b0;
    step();
    chk("to_next_r0ready", 32'(r0_ready), 32'd1);
    chk("to_next_err", 32'(err), 32'd0);
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
